// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Recovers operand B from an adder sum C (W+1 bits) and operand A (W bits),
//   B = C - A, one bit per clock, LSB first, over a single-bit datapath.
//   Results that do not fit in W unsigned bits are flagged on o_range_err.
//
// Optional feature macro: SUB_SATURATE_EN
//   defined   : on a range error o_B clamps (negative -> 0, overflow -> all ones)
//   undefined : o_B is the modular difference diff[W-1:0]
//   Latency and handshake are identical in both builds.
//
// Parameters
//   g_data_width : W, width of A and B (>= 1); C is W+1 bits
//
// Ports
//   i_clk        clock, all logic on rising edge
//   i_rst        synchronous active-high reset, aborts any in-flight operation
//   i_valid      request strobe; i_C and i_A are valid this cycle
//   i_C [W:0]    minuend (adder sum)
//   i_A [W-1:0]  subtrahend (adder operand A)
//   o_ready      block idle; a request is accepted this cycle
//   o_valid      one-cycle pulse: o_B / o_range_err just updated
//   o_B [W-1:0]  recovered operand (held between completions)
//   o_range_err  true C-A outside [0, 2^W-1] (held between completions)
//
// Handshake: a request is accepted on a rising edge where i_valid && o_ready.
//   o_ready is high only in IDLE; i_valid while busy is ignored, never queued.
//   The output has no backpressure: the result must be taken on the o_valid
//   cycle. Accept at edge E0 -> o_valid high in the cycle after edge E0+W+1;
//   the next accept can come at edge E0+W+3 at the earliest.
//
// The FSM state is visible as state_q for checkers bound to this module.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int g_data_width = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic [g_data_width:0]   i_C,
  input  logic [g_data_width-1:0] i_A,
  output logic                    o_ready,
  output logic                    o_valid,
  output logic [g_data_width-1:0] o_B,
  output logic                    o_range_err
);

  localparam int W  = g_data_width;
  localparam int CW = $clog2(W + 2);
  localparam logic [CW-1:0] LAST_BIT = CW'(W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W:0]      c_sh_q, c_sh_d;     // minuend, shifted right each bit
  logic [W:0]      a_sh_q, a_sh_d;     // zero-extended subtrahend
  logic [W-1:0]    res_q, res_d;       // diff bits collected MSB-in
  logic            borrow_q, borrow_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [W-1:0]    b_q, b_d;
  logic            err_q, err_d;

  // Single-bit full subtractor on the current LSBs.
  logic            c_bit, a_bit, diff_bit, borrow_nx;
  logic [W:0]      diff_full;          // full difference once bit W is processed

  assign c_bit     = c_sh_q[0];
  assign a_bit     = a_sh_q[0];
  assign diff_bit  = c_bit ^ a_bit ^ borrow_q;
  assign borrow_nx = (~c_bit & a_bit) | (~(c_bit ^ a_bit) & borrow_q);
  // After W shifts res_q holds diff[W-1:0]; the incoming bit is diff[W].
  assign diff_full = {diff_bit, res_q};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      c_sh_q   <= '0;
      a_sh_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      b_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_sh_q   <= c_sh_d;
      a_sh_q   <= a_sh_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      b_q      <= b_d;
      err_q    <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_valid) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == LAST_BIT) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    c_sh_d   = c_sh_q;
    a_sh_d   = a_sh_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;                   // o_valid is a pulse, never held
    b_d      = b_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          c_sh_d   = i_C;
          a_sh_d   = {1'b0, i_A};
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
        end
      end
      ST_SHIFT: begin
        c_sh_d   = c_sh_q >> 1;
        a_sh_d   = a_sh_q >> 1;
        res_d    = diff_full[W:1];
        borrow_d = borrow_nx;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          valid_d = 1'b1;
          // A final borrow means C < A; diff[W] set means C-A >= 2^W.
          err_d   = borrow_nx | diff_full[W];
`ifdef SUB_SATURATE_EN
          if (borrow_nx)         b_d = '0;
          else if (diff_full[W]) b_d = '1;
          else                   b_d = diff_full[W-1:0];
`else
          b_d     = diff_full[W-1:0];
`endif
        end
      end
      default: ;
    endcase
  end

  assign o_ready     = (state_q == ST_IDLE);
  assign o_valid     = valid_q;
  assign o_B         = b_q;
  assign o_range_err = err_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed bench for serial_subtractor at W=8. Inputs are driven and outputs
//   sampled on the falling clock edge. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  // Expected o_B for the two range-error flavours, per build.
`ifdef SUB_SATURATE_EN
  localparam logic [7:0] NEG_0_1   = 8'h00;  // 0 - 1
  localparam logic [7:0] NEG_100   = 8'h00;  // 100 - 200
  localparam logic [7:0] OVF_280   = 8'hFF;  // 300 - 20
`else
  localparam logic [7:0] NEG_0_1   = 8'hFF;
  localparam logic [7:0] NEG_100   = 8'h9C;  // -100 mod 256
  localparam logic [7:0] OVF_280   = 8'h18;  // 280 mod 256
`endif

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W:0]   in_c;
  logic [W-1:0] in_a;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_b;
  logic         out_err;

  int n_checks = 0;
  int n_errors = 0;

  serial_subtractor #(.g_data_width(W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (in_valid),
    .i_C         (in_c),
    .i_A         (in_a),
    .o_ready     (out_ready),
    .o_valid     (out_valid),
    .o_B         (out_b),
    .o_range_err (out_err)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking helper
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Waits (bounded) for o_ready, presents one request for one cycle, and
  // returns on the falling edge right after the accepting rising edge.
  task automatic start_req(input string tag, input logic [W:0] c,
                           input logic [W-1:0] a);
    int guard = 0;
    while (!out_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check({tag, ".ready"}, {31'd0, out_ready}, 32'd1);
    in_c     = c;
    in_a     = a;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for o_valid and checks latency, result and pulse width.
  task automatic wait_result(input string tag, input int exp_lat,
                             input logic [W-1:0] exp_b, input logic exp_err);
    int cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, ".latency"}, cnt, exp_lat);
    check({tag, ".valid"},   {31'd0, out_valid}, 32'd1);
    check({tag, ".B"},       {24'd0, out_b}, {24'd0, exp_b});
    check({tag, ".err"},     {31'd0, out_err}, {31'd0, exp_err});
    @(negedge clk);
    check({tag, ".pulse"},   {31'd0, out_valid}, 32'd0);
    check({tag, ".idle"},    {31'd0, out_ready}, 32'd1);
    check({tag, ".hold"},    {24'd0, out_b}, {24'd0, exp_b});
  endtask

  // Counts o_valid pulses over n cycles; none are expected.
  task automatic watch_quiet(input string tag, input int n);
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check({tag, ".no_pulse"}, pulses, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int rdy_cnt, rdy_sum, vld_cnt, vld_sum;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_c     = '0;
    in_a     = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("reset.valid", {31'd0, out_valid}, 32'd0);
    check("reset.B",     {24'd0, out_b}, 32'd0);
    check("reset.err",   {31'd0, out_err}, 32'd0);
    check("reset.ready", {31'd0, out_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset.ready", {31'd0, out_ready}, 32'd1);

    // Basic vectors: latency W+1 = 9 falling edges after the accept
    start_req("t300_45", 9'd300, 8'd45);   wait_result("t300_45", 9, 8'd255, 1'b0);
    start_req("t0_1",    9'd0,   8'd1);    wait_result("t0_1",    9, NEG_0_1, 1'b1);
    start_req("t511_0",  9'd511, 8'd0);    wait_result("t511_0",  9, 8'hFF, 1'b1);
    start_req("t100_200",9'd100, 8'd200);  wait_result("t100_200",9, NEG_100, 1'b1);
    start_req("t300_20", 9'd300, 8'd20);   wait_result("t300_20", 9, OVF_280, 1'b1);

    // Round trips: C = A + B from the adder, expect B back with no error
    start_req("rt_5a_a5", 9'd255, 8'h5A);  wait_result("rt_5a_a5", 9, 8'hA5, 1'b0);
    start_req("rt_ff_ff", 9'd510, 8'hFF);  wait_result("rt_ff_ff", 9, 8'hFF, 1'b0);
    start_req("rt_00_00", 9'd0,   8'h00);  wait_result("rt_00_00", 9, 8'h00, 1'b0);
    start_req("rt_80_80", 9'd256, 8'h80);  wait_result("rt_80_80", 9, 8'h80, 1'b0);

    // Request while busy is ignored and does not disturb the in-flight one
    start_req("busy", 9'd300, 8'd45);
    repeat (3) @(negedge clk);
    check("busy.ready_low", {31'd0, out_ready}, 32'd0);
    in_c = 9'd0; in_a = 8'd1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_result("busy", 5, 8'd255, 1'b0);
    watch_quiet("busy", 15);

    // i_valid held high: accepts at cycles 0, 11, 22; results at 10, 21, 32
    rdy_cnt = 0; rdy_sum = 0; vld_cnt = 0; vld_sum = 0;
    in_c = 9'd300; in_a = 8'd45; in_valid = 1'b1;
    for (int n = 0; n < 33; n++) begin
      if (out_ready) begin rdy_cnt++; rdy_sum += n; end
      if (out_valid) begin vld_cnt++; vld_sum += n; end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("hold.accepts",   rdy_cnt, 3);
    check("hold.accept_at", rdy_sum, 33);
    check("hold.results",   vld_cnt, 3);
    check("hold.result_at", vld_sum, 63);
    check("hold.B",         {24'd0, out_b}, 32'd255);
    watch_quiet("hold", 15);

    // Leave a result with err=1 and B nonzero, then abort mid-SHIFT
    start_req("pre_rst", 9'd511, 8'd0);    wait_result("pre_rst", 9, 8'hFF, 1'b1);
    start_req("abort", 9'd300, 8'd45);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.valid", {31'd0, out_valid}, 32'd0);
    check("abort.B",     {24'd0, out_b}, 32'd0);
    check("abort.err",   {31'd0, out_err}, 32'd0);
    check("abort.ready", {31'd0, out_ready}, 32'd1);
    watch_quiet("abort", 15);
    start_req("after_rst", 9'd300, 8'd45); wait_result("after_rst", 9, 8'd255, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
